uart_tx_responder: RTL and testbench

Memory-mapped UART transmitter sitting as a bus responder on the Core's memory bus, alongside Memory. The Core writes bytes into an internal FIFO through ordinary store instructions. The block serialises them 8N1, LSB first, on the board `tx` pin, and reports status and a programmable bit divisor through load instructions.

---
 rtl/uart_tx_responder_if.sv | 26 ++
 rtl/uart_tx_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_responder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_responder_if.sv
// Core memory-bus signals seen by the UART transmitter responder.
// The Core drives the strobes, address and store data; the responder drives load data.
`timescale 1ns/1ps
interface uart_tx_responder_if;
   logic        memory_read;
   logic        memory_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output memory_read,
      output memory_write,
      output address,
      output write_data,
      input  read_data
   );

   modport slave (
      input  memory_read,
      input  memory_write,
      input  address,
      input  write_data,
      output read_data
   );
endinterface

// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter: TX FIFO, status, programmable bit divisor, 8N1 LSB-first serialiser.
// Optional feature macro UART_TX_PARITY_EN adds an even-parity bit after the data bits.
`timescale 1ns/1ps
module uart_tx_responder #(
   parameter int unsigned CLK_FREQ     = 25_000_000,
   parameter int unsigned BIT_RATE     = 115200,
   parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_responder_if.slave bus,
   output logic               tx
);

   localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned RAW_DIV   = CLK_FREQ / BIT_RATE;
   localparam logic [15:0] RESET_DIV = (RAW_DIV < 2) ? 16'd2 : 16'(RAW_DIV);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic PARITY_FLAG = 1'b1;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   localparam logic PARITY_FLAG = 1'b0;
`endif

   logic          w_sel;
   logic [1:0]    w_index;
   logic          w_pushReq;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_statusRead;
   logic          w_divWrite;
   logic          w_busy;
   logic          w_bitEnd;
   logic          w_startFrame;
   logic          w_txNext;
   logic [15:0]   w_divValue;
   logic [AW:0]   w_count;
   logic [8:0]    w_count9;
   logic [7:0]    w_head;
   logic [31:0]   w_status;
   logic          w_unused;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wrPtr;
   logic [AW:0]   r_rdPtr;
   logic          r_overflow;
   logic [15:0]   r_divisor;

   state_t        r_state;
   state_t        w_stateNext;
   logic [15:0]   r_timer;
   logic [15:0]   w_timerNext;
   logic [15:0]   r_activeDiv;
   logic [15:0]   w_activeDivNext;
   logic [2:0]    r_bitCnt;
   logic [2:0]    w_bitCntNext;
   logic [7:0]    r_shift;
   logic [7:0]    w_shiftNext;
   logic          r_tx;
`ifdef UART_TX_PARITY_EN
   logic          r_parity;
   logic          w_parityNext;
`endif

   assign w_sel        = (bus.address[31:4] == BASE_ADDRESS[31:4]);
   assign w_index      = bus.address[3:2];
   assign w_pushReq    = bus.memory_write && w_sel && (w_index == 2'd0);
   assign w_statusRead = bus.memory_read && w_sel && (w_index == 2'd1);
   assign w_divWrite   = bus.memory_write && w_sel && (w_index == 2'd2);
   assign w_divValue   = (bus.write_data[15:0] < 16'd2) ? 16'd2 : bus.write_data[15:0];

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign w_empty  = (r_wrPtr == r_rdPtr);
   assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_count  = r_wrPtr - r_rdPtr;
   assign w_count9 = 9'(w_count);
   assign w_head   = r_mem[r_rdPtr[AW-1:0]];
   assign w_push   = w_pushReq && (!w_full || w_pop);
   assign w_busy   = (r_state != S_IDLE);
   assign w_bitEnd = (r_timer == 16'd0);
   assign tx       = r_tx;

   assign w_unused = ^{bus.address[1:0], bus.write_data[31:16], w_count9[8]};

   assign w_status = {16'h0000, w_count9[7:0], 3'b000, PARITY_FLAG,
                      r_overflow, w_busy, w_full, w_empty};

   always_comb begin
      bus.read_data = 32'h0000_0000;
      if (bus.memory_read && w_sel) begin
         case (w_index)
            2'd1:    bus.read_data = w_status;
            2'd2:    bus.read_data = {16'h0000, r_divisor};
            default: bus.read_data = 32'h0000_0000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr[AW-1:0]] <= bus.write_data[7:0];
      end
   end

   // A push into a full FIFO is only an overflow when no pop frees a slot that same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_overflow <= 1'b0;
         r_divisor  <= RESET_DIV;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pushReq && !w_push) begin
            r_overflow <= 1'b1;
         end else if (w_statusRead) begin
            r_overflow <= 1'b0;
         end
         if (w_divWrite) begin
            r_divisor <= w_divValue;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_activeDiv <= RESET_DIV;
         r_bitCnt    <= '0;
         r_shift     <= '0;
         r_tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_state     <= w_stateNext;
         r_timer     <= w_timerNext;
         r_activeDiv <= w_activeDivNext;
         r_bitCnt    <= w_bitCntNext;
         r_shift     <= w_shiftNext;
         r_tx        <= w_txNext;
`ifdef UART_TX_PARITY_EN
         r_parity    <= w_parityNext;
`endif
      end
   end

   // The end of a stop bit may launch the next queued byte directly, so frames abut with no idle gap.
   always_comb begin
      w_stateNext     = r_state;
      w_timerNext     = r_timer;
      w_activeDivNext = r_activeDiv;
      w_bitCntNext    = r_bitCnt;
      w_shiftNext     = r_shift;
      w_startFrame    = 1'b0;
      w_pop           = 1'b0;
      w_txNext        = 1'b1;
`ifdef UART_TX_PARITY_EN
      w_parityNext    = r_parity;
`endif

      if (r_state != S_IDLE) begin
         w_timerNext = w_bitEnd ? (r_activeDiv - 16'd1) : (r_timer - 16'd1);
      end

      case (r_state)
         S_IDLE: begin
            w_startFrame = !w_empty;
         end
         S_START: begin
            if (w_bitEnd) begin
               w_stateNext  = S_DATA;
               w_bitCntNext = 3'd0;
            end
         end
         S_DATA: begin
            if (w_bitEnd) begin
               if (r_bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_stateNext = S_PARITY;
`else
                  w_stateNext = S_STOP;
`endif
               end else begin
                  w_bitCntNext = r_bitCnt + 3'd1;
                  w_shiftNext  = {1'b0, r_shift[7:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bitEnd) begin
               w_stateNext = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_bitEnd) begin
               w_stateNext  = S_IDLE;
               w_startFrame = !w_empty;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase

      if (w_startFrame) begin
         w_pop           = 1'b1;
         w_stateNext     = S_START;
         w_shiftNext     = w_head;
         w_activeDivNext = r_divisor;
         w_timerNext     = r_divisor - 16'd1;
`ifdef UART_TX_PARITY_EN
         w_parityNext    = ^w_head;
`endif
      end

      case (w_stateNext)
         S_START:  w_txNext = 1'b0;
         S_DATA:   w_txNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_txNext = w_parityNext;
`endif
         default:  w_txNext = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed self-checking bench for uart_tx_responder: register map, framing, FIFO overflow,
// divisor handling and asynchronous reset; the line is logged every cycle and compared to ideal frames.
`timescale 1ns/1ps
module tb_uart_tx_responder;

   localparam logic [31:0] TXDATA_ADDR  = 32'h8000_0000;
   localparam logic [31:0] STATUS_ADDR  = 32'h8000_0004;
   localparam logic [31:0] DIVISOR_ADDR = 32'h8000_0008;
   localparam logic [31:0] SPARE_ADDR   = 32'h8000_000C;
   localparam int          LOG_SIZE     = 4096;

`ifdef UART_TX_PARITY_EN
   localparam int          NBITS    = 11;
   localparam bit          PARITY_ON = 1'b1;
   localparam logic [31:0] PAR_FLAG = 32'h0000_0010;
`else
   localparam int          NBITS    = 10;
   localparam bit          PARITY_ON = 1'b0;
   localparam logic [31:0] PAR_FLAG = 32'h0000_0000;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx;
   int   checkCount = 0;
   int   errorCount = 0;
   int   posCount = 0;
   logic txLog [LOG_SIZE];

   uart_tx_responder_if busIf();

   uart_tx_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) posCount++;

   // The line is recorded half a cycle after each edge, indexed by the number of edges seen.
   always @(negedge clk) begin
      if (posCount < LOG_SIZE) txLog[posCount] = tx;
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      busIf.memory_write = 1'b1;
      busIf.address      = addr;
      busIf.write_data   = data;
      @(negedge clk);
      busIf.memory_write = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      busIf.memory_read = 1'b1;
      busIf.address     = addr;
      #1 data = busIf.read_data;
      @(negedge clk);
      busIf.memory_read = 1'b0;
   endtask

   // Combinational look at a register without letting a clock edge see the read.
   task automatic peekRead(input logic [31:0] addr, output logic [31:0] data);
      busIf.memory_read = 1'b1;
      busIf.address     = addr;
      #1 data = busIf.read_data;
      busIf.memory_read = 1'b0;
   endtask

   task automatic waitIdle(input int maxCycles);
      logic [31:0] s;
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < maxCycles && !reached; i++) begin
         @(negedge clk);
         peekRead(STATUS_ADDR, s);
         if (s[2] == 1'b0 && s[0] == 1'b1) reached = 1'b1;
      end
      checkOutput("idleReached", reached, 1);
   endtask

   function automatic logic [127:0] expectWave(input logic [7:0] b, input int div);
      logic [127:0] w;
      int bitIdx;
      w = '1;
      for (int j = 0; j < NBITS * div; j++) begin
         bitIdx = j / div;
         if (bitIdx == 0) w[j] = 1'b0;
         else if (bitIdx <= 8) w[j] = b[bitIdx-1];
         else if (PARITY_ON && bitIdx == 9) w[j] = ^b;
         else w[j] = 1'b1;
      end
      return w;
   endfunction

   function automatic logic [127:0] captureWave(input int startIdx, input int len);
      logic [127:0] w;
      w = '1;
      for (int j = 0; j < len; j++) begin
         if (startIdx + j < LOG_SIZE) w[j] = txLog[startIdx + j];
      end
      return w;
   endfunction

   initial begin
      logic [31:0] rd;
      logic [7:0]  b;
      int n;
      int burstStart;
      int m;
      int r;

      busIf.memory_read  = 1'b0;
      busIf.memory_write = 1'b0;
      busIf.address      = 32'h0;
      busIf.write_data   = 32'h0;
      $display("[TB] start, frame bits = %0d", NBITS);

      repeat (3) @(negedge clk);
      reset = 1'b0;

      checkOutput("resetTx", tx, 1);
      checkOutput("readDataNoStrobe", busIf.read_data, 0);
      peekRead(STATUS_ADDR, rd);
      checkOutput("resetStatus", rd, 32'h0000_0001 | PAR_FLAG);
      peekRead(DIVISOR_ADDR, rd);
      checkOutput("resetDivisor", rd, 217);
      peekRead(SPARE_ADDR, rd);
      checkOutput("spareRead", rd, 0);
      peekRead(TXDATA_ADDR, rd);
      checkOutput("txdataRead", rd, 0);
      peekRead(32'h9000_0004, rd);
      checkOutput("unselectedRead", rd, 0);

      // Single byte at divisor 4.
      applyStimulus(DIVISOR_ADDR, 32'd4);
      peekRead(DIVISOR_ADDR, rd);
      checkOutput("divisor4", rd, 4);
      applyStimulus(TXDATA_ADDR, 32'h55);
      n = posCount;
      checkOutput("txBeforePop", tx, 1);
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusQueued", rd, 32'h0000_0100 | PAR_FLAG);
      @(negedge clk);
      checkOutput("txStartBit", tx, 0);
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusBusy", rd, 32'h0000_0005 | PAR_FLAG);
      repeat (NBITS * 4 - 1) @(negedge clk);
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusLastClock", rd, 32'h0000_0005 | PAR_FLAG);
      @(negedge clk);
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusDone", rd, 32'h0000_0001 | PAR_FLAG);
      checkOutput("frame55", captureWave(n + 1, NBITS * 4), expectWave(8'h55, 4));

      // Ten back-to-back writes: byte 0 leaves the FIFO at once, bytes 1..8 fill it, byte 9 is dropped.
      @(negedge clk);
      burstStart = posCount + 1;
      for (int i = 0; i < 10; i++) begin
         busIf.memory_write = 1'b1;
         busIf.address      = TXDATA_ADDR;
         busIf.write_data   = 32'(i);
         @(negedge clk);
      end
      busIf.memory_write = 1'b0;
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusOverflow", rd, 32'h0000_080E | PAR_FLAG);
      busRead(STATUS_ADDR, rd);
      checkOutput("statusReadPreClear", rd, 32'h0000_080E | PAR_FLAG);
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusCleared", rd, 32'h0000_0806 | PAR_FLAG);

      // Write onto the edge where the first frame ends and the full FIFO pops.
      while (posCount < burstStart + NBITS * 4) @(negedge clk);
      busIf.memory_write = 1'b1;
      busIf.address      = TXDATA_ADDR;
      busIf.write_data   = 32'h77;
      @(negedge clk);
      busIf.memory_write = 1'b0;
      peekRead(STATUS_ADDR, rd);
      checkOutput("fullPushPop", rd, 32'h0000_0806 | PAR_FLAG);

      waitIdle(2000);
      for (int k = 0; k < 10; k++) begin
         b = (k < 9) ? 8'(k) : 8'h77;
         checkOutput($sformatf("burstFrame%0d", k),
                     captureWave(burstStart + 1 + k * NBITS * 4, NBITS * 4), expectWave(b, 4));
      end
      checkOutput("txIdleAfterBurst", tx, 1);

      // Divisor clamping and a mid-frame divisor change.
      applyStimulus(DIVISOR_ADDR, 32'd1);
      peekRead(DIVISOR_ADDR, rd);
      checkOutput("divisorClamp1", rd, 2);
      applyStimulus(DIVISOR_ADDR, 32'd0);
      peekRead(DIVISOR_ADDR, rd);
      checkOutput("divisorClamp0", rd, 2);
      applyStimulus(DIVISOR_ADDR, 32'd4);
      @(negedge clk);
      m = posCount + 1;
      busIf.memory_write = 1'b1;
      busIf.address      = TXDATA_ADDR;
      busIf.write_data   = 32'h07;
      @(negedge clk);
      busIf.write_data   = 32'hC3;
      @(negedge clk);
      busIf.memory_write = 1'b0;
      while (posCount < m + 10) @(negedge clk);
      applyStimulus(DIVISOR_ADDR, 32'hABCD_0006);
      peekRead(DIVISOR_ADDR, rd);
      checkOutput("divisor6", rd, 6);
      waitIdle(2000);
      checkOutput("frameOldDiv", captureWave(m + 1, NBITS * 4), expectWave(8'h07, 4));
      checkOutput("frameNewDiv", captureWave(m + 1 + NBITS * 4, NBITS * 6), expectWave(8'hC3, 6));

      // Asynchronous reset in the middle of the data bits.
      applyStimulus(DIVISOR_ADDR, 32'd4);
      applyStimulus(TXDATA_ADDR, 32'hF0);
      r = posCount;
      applyStimulus(TXDATA_ADDR, 32'h0F);
      while (posCount < r + 6) @(negedge clk);
      checkOutput("txDataLow", tx, 0);
      #2 reset = 1'b1;
      #1 checkOutput("txResetImmediate", tx, 1);
      @(negedge clk);
      reset = 1'b0;
      peekRead(STATUS_ADDR, rd);
      checkOutput("statusAfterReset", rd, 32'h0000_0001 | PAR_FLAG);
      peekRead(DIVISOR_ADDR, rd);
      checkOutput("divisorAfterReset", rd, 217);
      repeat (30) @(negedge clk);
      checkOutput("txStaysIdle", tx, 1);
      peekRead(STATUS_ADDR, rd);
      checkOutput("queueDiscarded", rd, 32'h0000_0001 | PAR_FLAG);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
